// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle produced by vga_timing_gen: pixel enable, position, blanking, syncs, strobes.
interface vga_timing_if;
    logic        pix_ce;
    logic [9:0]  x_o;
    logic [9:0]  y_o;
    logic        de_o;
    logic        hs_n_o;
    logic        vs_n_o;
    logic        line_start_o;
    logic        frame_start_o;
    logic [15:0] frame_cnt_o;

    modport master (
        output pix_ce, x_o, y_o, de_o, hs_n_o, vs_n_o,
               line_start_o, frame_start_o, frame_cnt_o
    );

    modport slave (
        input  pix_ce, x_o, y_o, de_o, hs_n_o, vs_n_o,
               line_start_o, frame_start_o, frame_cnt_o
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: one pixel every second clk, registered position/sync/blank outputs.
// Define VGA_TIMING_FRAME_CNT_EN to build the 16-bit frame counter; otherwise frame_cnt_o is 0.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master vga
);
    localparam int unsigned CW      = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic          pix_ce_q;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;
    logic          de_q;
    logic          hs_n_q;
    logic          vs_n_q;
    logic          line_start_q;
    logic          frame_start_q;

    logic          h_wrap_c;
    logic          de_c;
    logic          hs_n_c;
    logic          vs_n_c;
    logic          line_start_c;
    logic          frame_start_c;

    // Decode of the current (pre-advance) counter position
    always_comb begin
        h_wrap_c      = (h_cnt == H_LAST);
        de_c          = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_n_c        = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
        vs_n_c        = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
        line_start_c  = pix_ce_q && (h_cnt == '0);
        frame_start_c = line_start_c && (v_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_ce_q      <= 1'b0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            hs_n_q        <= 1'b1;
            vs_n_q        <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_ce_q      <= !pix_ce_q;
            line_start_q  <= line_start_c;
            frame_start_q <= frame_start_c;
            // Outputs take the position being left, so all five stay aligned
            if (pix_ce_q) begin
                x_q    <= h_cnt;
                y_q    <= v_cnt;
                de_q   <= de_c;
                hs_n_q <= hs_n_c;
                vs_n_q <= vs_n_c;
                if (h_wrap_c) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
                end else begin
                    h_cnt <= h_cnt + CW'(1);
                end
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (frame_start_c) begin
            frame_cnt_q <= frame_cnt_q + 16'(1);
        end
    end

    assign vga.frame_cnt_o = frame_cnt_q;
`else
    assign vga.frame_cnt_o = '0;
`endif

    assign vga.pix_ce        = pix_ce_q;
    assign vga.x_o           = x_q;
    assign vga.y_o           = y_q;
    assign vga.de_o          = de_q;
    assign vga.hs_n_o        = hs_n_q;
    assign vga.vs_n_o        = vs_n_q;
    assign vga.line_start_o  = line_start_q;
    assign vga.frame_start_o = frame_start_q;
endmodule
